// File: rtl/seq_gen.sv
// seq_gen: replays a fixed 1-bit character pattern, one character per clock cycle.
module seq_gen #(
  parameter int LEN = 4,
  parameter logic [8*LEN-1:0] PATTERN = "-___",
  parameter bit LOOP = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       out,
  output logic                       done,
  output logic [$clog2(LEN+1)-1:0]   index
);
  localparam int W = $clog2(LEN+1);
  localparam logic [W-1:0] LAST = W'(LEN-1);
  localparam logic [W-1:0] TERM = W'(LEN);
  logic [2**W-1:0] bits;
  if (LEN < 1) begin : g_bad_len
    $error("seq_gen: LEN must be at least 1");
  end
  // Pattern decode is resolved at elaboration; unused and terminal slots read low.
  for (genvar i = 0; i < 2**W; i++) begin : g_dec
    if (i < LEN) begin : g_c
      localparam logic [7:0] C = PATTERN[8*(LEN-i)-1 -: 8];
      assign bits[i] = (C == 8'h2d) || (C == 8'h31);
    end else begin : g_z
      assign bits[i] = 1'b0;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) index <= '0;
    else if (index < LAST) index <= index + W'(1);
    else if (index == LAST) index <= LOOP ? '0 : TERM;
  assign out  = bits[index];
  assign done = !LOOP && (index == TERM);
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: random reset pulses; all instances compared against a cycle-count reference model.
module tb_seq_gen;
  localparam int N = 7;
  logic clock = 1'b0;
  logic reset;
  logic o [N];
  logic d [N];
  logic [4:0] i0, i1, i3;
  logic [1:0] i2;
  logic [2:0] i4;
  logic       i5, i6;
  int idx [N];
  int compared = 0;
  int mismatched = 0;
  string pat [N] = '{"-_______-___________", "__--___-_____--_____", "-_-",
                     "_-____-____-________", "1x0-", "-", "-"};
  bit lp [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clock = ~clock;

  seq_gen #(.LEN(20), .PATTERN("-_______-___________"), .LOOP(1'b0)) u0 (.clock(clock), .reset(reset), .out(o[0]), .done(d[0]), .index(i0));
  seq_gen #(.LEN(20), .PATTERN("__--___-_____--_____"), .LOOP(1'b0)) u1 (.clock(clock), .reset(reset), .out(o[1]), .done(d[1]), .index(i1));
  seq_gen #(.LEN(3),  .PATTERN("-_-"),                  .LOOP(1'b1)) u2 (.clock(clock), .reset(reset), .out(o[2]), .done(d[2]), .index(i2));
  seq_gen #(.LEN(20), .PATTERN("_-____-____-________"), .LOOP(1'b0)) u3 (.clock(clock), .reset(reset), .out(o[3]), .done(d[3]), .index(i3));
  seq_gen #(.LEN(4),  .PATTERN("1x0-"),                 .LOOP(1'b0)) u4 (.clock(clock), .reset(reset), .out(o[4]), .done(d[4]), .index(i4));
  seq_gen #(.LEN(1),  .PATTERN("-"),                    .LOOP(1'b0)) u5 (.clock(clock), .reset(reset), .out(o[5]), .done(d[5]), .index(i5));
  seq_gen #(.LEN(1),  .PATTERN("-"),                    .LOOP(1'b1)) u6 (.clock(clock), .reset(reset), .out(o[6]), .done(d[6]), .index(i6));

  always_comb begin
    idx[0] = int'(i0);
    idx[1] = int'(i1);
    idx[2] = int'(i2);
    idx[3] = int'(i3);
    idx[4] = int'(i4);
    idx[5] = int'(i5);
    idx[6] = int'(i6);
  end

  function automatic bit high_char(string p, int k);
    byte c;
    c = p[k];
    return (c == "-") || (c == "1");
  endfunction

  // Expected behaviour after k clock edges since reset release.
  function automatic bit want_out(int n, int k);
    int len = pat[n].len();
    if (lp[n]) return high_char(pat[n], k % len);
    return (k < len) ? high_char(pat[n], k) : 1'b0;
  endfunction

  function automatic int want_idx(int n, int k);
    int len = pat[n].len();
    if (lp[n]) return k % len;
    return (k < len) ? k : len;
  endfunction

  function automatic bit want_done(int n, int k);
    return !lp[n] && (k >= pat[n].len());
  endfunction

  task automatic check(string tag, int n, int k, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s u%0d k=%0d: observed %0h expected %0h", tag, n, k, obs, exp);
    end
  endtask

  task automatic check_all(int k);
    for (int n = 0; n < N; n++) begin
      check("out", n, k, {31'd0, o[n]}, {31'd0, want_out(n, k)});
      check("done", n, k, {31'd0, d[n]}, {31'd0, want_done(n, k)});
      check("index", n, k, idx[n], want_idx(n, k));
    end
  endtask

  initial begin
    int cyc;
    int hold;
    reset = 1'b1;
    #3;
    check_all(0);
    for (int t = 0; t < 12; t++) begin
      if (t > 0) begin
        @(posedge clock);
        #($urandom_range(1, 8));
        reset = 1'b1;
        #1;
        check_all(0);
        hold = $urandom_range(0, 3);
        repeat (hold) begin
          @(posedge clock);
          #1;
          check_all(0);
        end
      end
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check_all(0);
      cyc = (t == 0) ? 45 : $urandom_range(1, 30);
      for (int k = 1; k <= cyc; k++) begin
        @(posedge clock);
        #1;
        check_all(k);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Parameterised waveform/stimulus generator: replays a fixed 1-bit pattern, given as a character string, one character per clock cycle.
- Drives formal/simulation stimulus for other blocks, such as reset, request or strobe lines in property demos.
- One instance per generated signal.
- A pure sequencer: no data inputs, only clock and reset.

Parameters:
- PATTERN, default "-___", pattern string. Leftmost character is emitted first. '-' or '1' = high; '_' or '0' = low; any other character = low.
- LEN, default 4, number of characters in PATTERN. Must equal the string length; PATTERN occupies 8*LEN bits.
- LOOP, default 0. 0 = after the last character, out goes low and stays low. 1 = wrap to the first character and repeat forever.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- out, output, 1, current pattern bit.
- done, output, 1, high once the pattern has been fully emitted (LOOP=0 only).
- index, output, $clog2(LEN+1), current character position, for debug and coverage.

Behaviour:
- State: index register, width $clog2(LEN+1).
- Reset:
  - Asynchronous; while reset=1, index=0.
  - out = decode of character 0 (combinational from index), so out reflects PATTERN[0] during reset.
  - done=0.
- Cycle indexing:
  - Cycle k = the k-th clock period since time zero / reset release.
  - out during cycle k = decode(char k), where char 0 is the leftmost character (bits [8*LEN-1 -: 8]).
  - Char k occupies bits [8*(LEN-k)-1 -: 8].
- Advance: at each rising clock edge with reset=0:
  - if index < LEN-1, index <= index+1;
  - if index == LEN-1: LOOP=1 → index <= 0; LOOP=0 → index <= LEN (terminal).
  - In terminal state index holds at LEN.
- Output decode:
  - out is purely combinational from index, no extra latency.
  - out = 1 iff index < LEN and char(index) is '-' or '1'.
  - out = 0 for index == LEN.
- done:
  - LOOP=0: done = (index == LEN).
  - LOOP=1: done is tied 0.
- Reset mid-pattern: index returns to 0 immediately (asynchronously); the pattern restarts at char 0 in the cycle after release.
- A reset asserted while done=1 also restarts the pattern.
- Reset released coincident with a clock edge: that edge does not advance index; the first advance is on the next edge.
- LEN=1:
  - LOOP=1 → out is constant at decode(char 0).
  - LOOP=0 → one cycle of char 0, then terminal.
- Invalid characters decode as 0; no error output.
- Elaboration: LEN < 1 is illegal.
- No X on outputs at any time after reset has been asserted once.

Test Plan:
- PATTERN="-_______-___________", LEN=20, LOOP=0, reset pulsed at t=0 → out=1 in cycles 0 and 8, 0 elsewhere in 0..19; done=1 from cycle 20; out=0 thereafter.
- PATTERN="__--___-_____--_____", LEN=20 → out high exactly in cycles 2, 3, 7, 13, 14; index counts 0..19, then holds at 20.
- PATTERN="-_-", LEN=3, LOOP=1 → out sequence 1,0,1,1,0,1,1,0,1…; index wraps 2→0; done stays 0.
- Reset asserted asynchronously mid-cycle 5 of "_-____-____-________" → index=0 immediately, out=0 (char 0); after release, out=1 in the 2nd cycle after release (char 1).
- PATTERN="1x0-", LEN=4 → out 1,0,0,1; the invalid 'x' decodes 0.
- LEN=1, PATTERN="-", LOOP=0 → out=1 for one cycle, then 0 with done=1; with LOOP=1, out stays 1 permanently.
